// File: rtl/acc_job_ctrl.sv
// Job sequencer for the motion-estimation accelerator: streams the current block and search
// window into their memories, starts the engine, times the run and reports completion status.
module acc_job_ctrl #(
    parameter int unsigned CYC_W   = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_reload_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [7:0]       s_data_i,
    output logic             curr_mem_we_o,
    output logic [7:0]       curr_mem_waddr_o,
    output logic [7:0]       curr_mem_wdata_o,
    output logic             search_mem_we_o,
    output logic [9:0]       search_mem_waddr_o,
    output logic [7:0]       search_mem_wdata_o,
    output logic             acc_start_o,
    input  logic             acc_finish_i,
    input  logic             acc_busy_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_o,
    output logic [CYC_W-1:0] cycles_o
);

    localparam logic [CYC_W-1:0] TimeoutCnt = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0] CntMax     = '1;

    typedef enum logic [2:0] {
        StIdle, StLoadCurr, StLoadSrch, StDrain, StStart, StRun, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             curr_valid_q, curr_valid_d;
    logic             init_q;
    logic [CYC_W-1:0] run_q, run_d, run_k;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic [1:0]       err_q, err_d;
    logic             cwe_q, cwe_d, swe_q, swe_d;
    logic [7:0]       caddr_q, caddr_d, cdata_q, cdata_d, sdata_q, sdata_d;
    logic [9:0]       saddr_q, saddr_d;
    logic             beat, cmd_acc;

    // init_q keeps cmd_ready low while reset is applied so every output reads 0 then.
    assign cmd_ready_o = (state_q == StIdle) && init_q && !acc_busy_i;
    assign s_ready_o   = (state_q == StLoadCurr) || (state_q == StLoadSrch);
    assign beat        = s_valid_i && s_ready_o;
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;
    assign run_k       = (run_q == CntMax) ? run_q : run_q + CYC_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        curr_valid_d = curr_valid_q;
        run_d        = run_q;
        cycles_d     = cycles_q;
        err_d        = err_q;
        cwe_d        = 1'b0;
        caddr_d      = caddr_q;
        cdata_d      = cdata_q;
        swe_d        = 1'b0;
        saddr_d      = saddr_q;
        sdata_d      = sdata_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_acc) begin
                    cnt_d = '0;
                    if (cmd_reload_i) begin
                        state_d = StLoadCurr;
                    end else if (curr_valid_q) begin
                        state_d = StLoadSrch;
                    end else begin
                        state_d  = StDone;
                        err_d    = 2'd2;
                        cycles_d = '0;
                    end
                end
            end
            StLoadCurr: begin
                if (beat) begin
                    cwe_d   = 1'b1;
                    caddr_d = cnt_q[7:0];
                    cdata_d = s_data_i;
                    if (cnt_q == 10'd255) begin
                        cnt_d        = '0;
                        curr_valid_d = 1'b1;
                        state_d      = StLoadSrch;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            StLoadSrch: begin
                if (beat) begin
                    swe_d   = 1'b1;
                    saddr_d = cnt_q;
                    sdata_d = s_data_i;
                    if (cnt_q == 10'd1023) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            StDrain: state_d = StStart;
            StStart: begin
                run_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                run_d = run_k;
                // Finish takes priority over a timeout landing in the same cycle.
                if (acc_finish_i) begin
                    cycles_d = run_k;
                    err_d    = 2'd0;
                    state_d  = StDone;
                end else if (run_k == TimeoutCnt) begin
                    cycles_d = TimeoutCnt;
                    err_d    = 2'd1;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            curr_valid_q <= 1'b0;
            init_q       <= 1'b0;
            run_q        <= '0;
            cycles_q     <= '0;
            err_q        <= '0;
            cwe_q        <= 1'b0;
            caddr_q      <= '0;
            cdata_q      <= '0;
            swe_q        <= 1'b0;
            saddr_q      <= '0;
            sdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            curr_valid_q <= curr_valid_d;
            init_q       <= 1'b1;
            run_q        <= run_d;
            cycles_q     <= cycles_d;
            err_q        <= err_d;
            cwe_q        <= cwe_d;
            caddr_q      <= caddr_d;
            cdata_q      <= cdata_d;
            swe_q        <= swe_d;
            saddr_q      <= saddr_d;
            sdata_q      <= sdata_d;
        end
    end

    assign curr_mem_we_o      = cwe_q;
    assign curr_mem_waddr_o   = caddr_q;
    assign curr_mem_wdata_o   = cdata_q;
    assign search_mem_we_o    = swe_q;
    assign search_mem_waddr_o = saddr_q;
    assign search_mem_wdata_o = sdata_q;
    assign acc_start_o        = (state_q == StStart);
    assign busy_o             = (state_q != StIdle);
    assign done_o             = (state_q == StDone);
    assign err_o              = err_q;
    assign cycles_o           = cycles_q;

endmodule

// File: tb/tb_acc_job_ctrl.sv
// Directed bench for acc_job_ctrl: a job-timeline model checked every cycle, a memory
// scoreboard, and hand-computed latency/status expectations for each scenario.
module tb_acc_job_ctrl;

    localparam int unsigned CYC_W   = 16;
    localparam int unsigned TIMEOUT = 100;

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready, cmd_reload;
    logic             s_valid, s_ready;
    logic [7:0]       s_data;
    logic             curr_we, search_we;
    logic [7:0]       curr_waddr, curr_wdata, search_wdata;
    logic [9:0]       search_waddr;
    logic             acc_start, acc_finish, acc_busy, busy, done;
    logic [1:0]       err;
    logic [CYC_W-1:0] cycles;

    acc_job_ctrl #(.CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_reload_i(cmd_reload),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .curr_mem_we_o(curr_we), .curr_mem_waddr_o(curr_waddr), .curr_mem_wdata_o(curr_wdata),
        .search_mem_we_o(search_we), .search_mem_waddr_o(search_waddr),
        .search_mem_wdata_o(search_wdata),
        .acc_start_o(acc_start), .acc_finish_i(acc_finish), .acc_busy_i(acc_busy),
        .busy_o(busy), .done_o(done), .err_o(err), .cycles_o(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int i);
        case (pat)
            0:       return 8'(i % 256);
            1:       return 8'(255 - (i % 256));
            default: return 8'((i * 7 + 3) % 256);
        endcase
    endfunction

    // Job-timeline model: a job is a run of beats, two bookkeeping cycles, a timed run, done.
    localparam int PhIdle = 0, PhLoad = 1, PhPost = 2, PhRun = 3, PhDone = 4;
    int          m_ph, m_beat, m_total, m_post;
    bit          m_init, m_cv, m_reload;
    int unsigned m_k;
    bit          e_cwe, e_swe;
    int          e_caddr, e_cdata, e_saddr, e_sdata, e_err, e_cycles;

    task automatic model_reset();
        m_ph = PhIdle; m_init = 0; m_cv = 0; m_beat = 0; m_total = 0; m_post = 0; m_k = 0;
        e_cwe = 0; e_swe = 0; e_caddr = 0; e_cdata = 0; e_saddr = 0; e_sdata = 0;
        e_err = 0; e_cycles = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
                check("rst_cmd_ready", 32'(cmd_ready), 0);
                check("rst_outputs", {search_waddr, curr_waddr, curr_wdata, search_wdata}, 0);
            end
            check("cmd_ready", 32'(cmd_ready),
                  32'(m_ph == PhIdle && m_init && !acc_busy));
            check("s_ready", 32'(s_ready), 32'(m_ph == PhLoad));
            check("busy", 32'(busy), 32'(m_ph != PhIdle));
            check("acc_start", 32'(acc_start), 32'(m_ph == PhPost && m_post == 1));
            check("done", 32'(done), 32'(m_ph == PhDone));
            check("err", 32'(err), 32'(e_err));
            check("cycles", 32'(cycles), 32'(e_cycles));
            check("curr_we", 32'(curr_we), 32'(e_cwe));
            check("search_we", 32'(search_we), 32'(e_swe));
            if (e_cwe) begin
                check("curr_waddr", 32'(curr_waddr), 32'(e_caddr));
                check("curr_wdata", 32'(curr_wdata), 32'(e_cdata));
            end
            if (e_swe) begin
                check("search_waddr", 32'(search_waddr), 32'(e_saddr));
                check("search_wdata", 32'(search_wdata), 32'(e_sdata));
            end
            if (rst_n) begin
                e_cwe = 0;
                e_swe = 0;
                case (m_ph)
                    PhIdle: if (m_init && !acc_busy && cmd_valid) begin
                        m_reload = cmd_reload;
                        m_beat   = 0;
                        m_total  = cmd_reload ? 1280 : 1024;
                        if (!cmd_reload && !m_cv) begin
                            m_ph = PhDone; e_err = 2; e_cycles = 0;
                        end else begin
                            m_ph = PhLoad;
                        end
                    end
                    PhLoad: if (s_valid) begin
                        if (m_reload && m_beat < 256) begin
                            e_cwe = 1; e_caddr = m_beat; e_cdata = int'(s_data);
                        end else begin
                            e_swe = 1; e_saddr = m_beat - (m_reload ? 256 : 0);
                            e_sdata = int'(s_data);
                        end
                        m_beat++;
                        if (m_reload && m_beat == 256) m_cv = 1;
                        if (m_beat == m_total) begin
                            m_ph = PhPost; m_post = 2;
                        end
                    end
                    PhPost: if (m_post == 2) m_post = 1; else begin m_ph = PhRun; m_k = 0; end
                    PhRun: begin
                        if (m_k < (32'd1 << CYC_W) - 1) m_k++;
                        if (acc_finish) begin
                            m_ph = PhDone; e_err = 0; e_cycles = int'(m_k);
                        end else if (m_k == TIMEOUT) begin
                            m_ph = PhDone; e_err = 1; e_cycles = int'(TIMEOUT);
                        end
                    end
                    default: m_ph = PhIdle;
                endcase
                m_init = 1;
            end
        end
    end

    // Scoreboard of what actually reached the memory ports.
    logic [7:0]  curr_mem[256];
    logic [7:0]  search_mem[1024];
    int          curr_hits[256];
    int          search_hits[1024];
    int          n_cw, n_sw, n_start;
    int unsigned last_w_cyc;

    task automatic clear_sb();
        foreach (curr_hits[j]) curr_hits[j] = 0;
        foreach (search_hits[j]) search_hits[j] = 0;
        n_cw = 0; n_sw = 0; n_start = 0; last_w_cyc = 0;
    endtask

    initial begin
        clear_sb();
        forever begin
            @(negedge clk);
            if (curr_we) begin
                curr_mem[curr_waddr] = curr_wdata;
                curr_hits[curr_waddr]++;
                n_cw++;
                last_w_cyc = cyc;
            end
            if (search_we) begin
                search_mem[search_waddr] = search_wdata;
                search_hits[search_waddr]++;
                n_sw++;
                last_w_cyc = cyc;
            end
            if (acc_start) n_start++;
        end
    end

    task automatic check_mem(input string name, input bit is_curr, input int n, input int pat,
                             input int base);
        int bad = 0;
        for (int j = 0; j < n; j++) begin
            if (is_curr) begin
                if (curr_hits[j] != 1 || curr_mem[j] != pat_byte(pat, base + j)) bad++;
            end else begin
                if (search_hits[j] != 1 || search_mem[j] != pat_byte(pat, base + j)) bad++;
            end
        end
        check(name, 32'(bad), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit reload, output int unsigned acc_cyc);
        cmd_valid  = 1'b1;
        cmd_reload = reload;
        acc_cyc    = 0;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (cmd_ready) begin
                acc_cyc = cyc;
                step();
                cmd_valid = 1'b0;
                return;
            end
            step();
        end
        cmd_valid = 1'b0;
        check("cmd_accept_bound", 0, 1);
    endtask

    task automatic stream(input int n, input int pat, input int gap_pct,
                          output int unsigned last_cyc);
        int i = 0;
        int guard = 0;
        last_cyc = 0;
        while (i < n && guard < 20000) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? pat_byte(pat, i) : 8'($urandom);
            #1;
            if (s_valid && s_ready) begin
                last_cyc = cyc;
                i++;
            end
            step();
            guard++;
        end
        s_valid = 1'b0;
        if (i < n) check("stream_bound", 32'(i), 32'(n));
    endtask

    task automatic wait_start(output int unsigned sc);
        sc = 0;
        for (int t = 0; t < 20; t++) begin
            if (acc_start) begin
                sc = cyc;
                return;
            end
            step();
        end
        check("start_bound", 0, 1);
    endtask

    task automatic finish_after(input int d);
        repeat (d) step();
        acc_finish = 1'b1;
        acc_busy   = 1'b0;
        step();
        acc_finish = 1'b0;
    endtask

    task automatic wait_done(output int unsigned dc, output logic [1:0] e,
                             output logic [CYC_W-1:0] cy);
        dc = 0; e = 0; cy = 0;
        for (int t = 0; t < 300; t++) begin
            if (done) begin
                dc = cyc; e = err; cy = cycles;
                step();
                return;
            end
            step();
        end
        check("done_bound", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    int unsigned      c, s, dc, lb, snap_c, snap_s;
    logic [1:0]       e;
    logic [CYC_W-1:0] cy;

    initial begin
        rst_n = 1'b1; cmd_valid = 0; cmd_reload = 0; s_valid = 0; s_data = 0;
        acc_finish = 0; acc_busy = 0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        check("reset_busy", 32'(busy), 0);
        check("reset_cmd_ready", 32'(cmd_ready), 0);
        check("reset_err_cycles", {14'd0, err, cycles}, 0);
        rst_n = 1'b1;
        step();

        // Reuse with no block ever loaded.
        clear_sb();
        send_cmd(0, c);
        wait_done(dc, e, cy);
        check("t3_done_lat", dc, c + 1);
        check("t3_err", 32'(e), 2);
        check("t3_no_writes", 32'(n_cw + n_sw), 0);
        check("t3_no_start", 32'(n_start), 0);

        // Full job, continuous stream, finish 40 cycles after start.
        clear_sb();
        send_cmd(1, c);
        stream(1280, 0, 0, lb);
        wait_start(s);
        acc_busy = 1'b1;
        check("t1_last_beat", lb, c + 1280);
        check("t1_start_lat", s, c + 1282);
        check("t1_last_write", last_w_cyc, c + 1281);
        finish_after(40);
        wait_done(dc, e, cy);
        check("t1_done_lat", dc, s + 41);
        check("t1_err", 32'(e), 0);
        check("t1_cycles", 32'(cy), 40);
        check("t1_start_count", 32'(n_start), 1);
        check("t1_curr_count", 32'(n_cw), 256);
        check("t1_search_count", 32'(n_sw), 1024);
        check_mem("t1_curr_mem", 1, 256, 0, 0);
        check_mem("t1_search_mem", 0, 1024, 0, 256);

        // Reuse job: search window only.
        clear_sb();
        send_cmd(0, c);
        stream(1024, 1, 0, lb);
        wait_start(s);
        acc_busy = 1'b1;
        check("t2_start_lat", s, c + 1026);
        check("t2_start_after_beat", s, lb + 2);
        finish_after(5);
        wait_done(dc, e, cy);
        check("t2_err", 32'(e), 0);
        check("t2_cycles", 32'(cy), 5);
        check("t2_curr_count", 32'(n_cw), 0);
        check("t2_search_count", 32'(n_sw), 1024);
        check_mem("t2_search_mem", 0, 1024, 1, 0);

        // Gapped stream; finish lands on the timeout cycle.
        clear_sb();
        send_cmd(1, c);
        stream(1280, 2, 30, lb);
        wait_start(s);
        acc_busy = 1'b1;
        check("t5_start_after_beat", s, lb + 2);
        finish_after(100);
        wait_done(dc, e, cy);
        check("t5_done_lat", dc, s + 101);
        check("t5_err", 32'(e), 0);
        check("t5_cycles", 32'(cy), 100);
        check("t5_counts", 32'(n_cw * 10000 + n_sw), 256 * 10000 + 1024);
        check_mem("t5_curr_mem", 1, 256, 2, 0);
        check_mem("t5_search_mem", 0, 1024, 2, 256);

        // Timeout with the accelerator still busy.
        clear_sb();
        send_cmd(0, c);
        stream(1024, 0, 0, lb);
        wait_start(s);
        acc_busy = 1'b1;
        wait_done(dc, e, cy);
        check("t4_done_lat", dc, s + 101);
        check("t4_err", 32'(e), 1);
        check("t4_cycles", 32'(cy), 100);
        cmd_valid  = 1'b1;
        cmd_reload = 1'b0;
        for (int t = 0; t < 5; t++) begin
            #1 check("t4_blocked", 32'(cmd_ready), 0);
            step();
        end
        acc_busy  = 1'b0;
        cmd_valid = 1'b0;
        #1 check("t4_released", 32'(cmd_ready), 1);
        step();

        // Reset during the search load, then a reuse request.
        clear_sb();
        send_cmd(1, c);
        stream(756, 0, 0, lb);
        s_valid = 1'b1;
        s_data  = 8'hA5;
        rst_n   = 1'b0;
        snap_c  = n_cw;
        snap_s  = n_sw;
        repeat (3) begin
            step();
            check("t6_rst_busy_ready", {30'd0, busy, cmd_ready}, 0);
        end
        rst_n = 1'b1;
        repeat (5) step();
        s_valid = 1'b0;
        check("t6_no_curr_writes", 32'(n_cw), snap_c);
        check("t6_no_search_writes", 32'(n_sw), snap_s);
        send_cmd(0, c);
        wait_done(dc, e, cy);
        check("t6_done_lat", dc, c + 1);
        check("t6_err", 32'(e), 2);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
